// File: rtl/adder8_burst_accumulator.sv
// adder8_burst_accumulator: sums a programmable-length burst of 9-bit
// {cout, sum} adder results into an ACC_W-bit total. The total, a sticky
// overflow flag and the beat count are then held on a valid/ready port.
// Optional build macro ACC_SATURATE_EN: clamp the total at all-ones on
// overflow instead of wrapping.
module adder8_burst_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_cout,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic [CNT_W:0]    out_count,
  output logic              busy
);

  localparam int SUM_W = ACC_W + 1;
  localparam int LEN_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_len;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_beat;
  logic [SUM_W-1:0] w_sum;
  logic             w_carry;
  logic [LEN_W-1:0] w_count_nx;

  // Beat acceptance and the widened add that exposes the carry out of the MSB
  always_comb begin
    w_beat     = in_valid && (r_state == ACCUM);
    w_sum      = {1'b0, r_acc} + SUM_W'({in_cout, in_sum});
    w_carry    = w_sum[ACC_W];
    w_count_nx = r_count + LEN_W'(1);
  end

  // Burst control FSM with registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            // A zero length field encodes the maximum burst of 2^CNT_W beats
            r_len   <= (burst_len == '0) ? {1'b1, {CNT_W{1'b0}}}
                                         : {1'b0, burst_len};
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_beat) begin
`ifdef ACC_SATURATE_EN
            // Once clamped the total stays at all-ones for the rest of the burst
            r_acc <= (w_carry || r_ovf) ? '1 : w_sum[ACC_W-1:0];
`else
            r_acc <= w_sum[ACC_W-1:0];
`endif
            r_ovf   <= r_ovf | w_carry;
            r_count <= w_count_nx;
            if (w_count_nx == r_len) begin
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = r_out_valid;
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_count;
  assign busy      = r_busy;

endmodule

// File: tb/tb_adder8_burst_accumulator.sv
// Directed self-checking bench for adder8_burst_accumulator.
module tb_adder8_burst_accumulator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] burst_len;
  logic       in_valid;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [11:0] out_acc;
  logic       out_ovf;
  logic [4:0] out_count;
  logic       busy;

  int n_cmp;
  int n_err;

  adder8_burst_accumulator #(
    .DATA_W(8),
    .ACC_W (12),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .burst_len(burst_len),
    .in_valid (in_valid),
    .in_sum   (in_sum),
    .in_cout  (in_cout),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_ovf  (out_ovf),
    .out_count(out_count),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] len);
    start = 1'b1;
    burst_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic do_beat(input logic c, input logic [7:0] s);
    in_valid = 1'b1;
    in_cout = c;
    in_sum = s;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_cmp++; if (out_acc !== 12'd0) begin n_err++; $display("FAIL reset_acc got %0d exp 0", out_acc); end
    n_cmp++; if (out_count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", out_count); end
    n_cmp++; if ({in_ready, out_valid, out_ovf, busy} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b exp 0000", {in_ready, out_valid, out_ovf, busy}); end
    tick();
    rst = 1'b0;
    // beats offered in IDLE must be ignored
    in_valid = 1'b1; in_cout = 1'b1; in_sum = 8'd77;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL idle_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (out_count !== 5'd0 || out_acc !== 12'd0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_ignore got cnt=%0d acc=%0d busy=%b exp 0/0/0", out_count, out_acc, busy); end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_start(4'd2);
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL basic_accum got rdy=%b busy=%b exp 1/1", in_ready, busy); end
    do_beat(1'b0, 8'd19);
    n_cmp++; if (out_valid !== 1'b0 || out_acc !== 12'd19) begin n_err++; $display("FAIL basic_mid got v=%b acc=%0d exp 0/19", out_valid, out_acc); end
    do_beat(1'b0, 8'd255);
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL basic_valid got v=%b rdy=%b exp 1/0", out_valid, in_ready); end
    n_cmp++; if (out_acc !== 12'd274 || out_ovf !== 1'b0 || out_count !== 5'd2) begin n_err++; $display("FAIL basic_result got acc=%0d ovf=%b cnt=%0d exp 274/0/2", out_acc, out_ovf, out_count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_acc !== 12'd274) begin n_err++; $display("FAIL basic_release got v=%b busy=%b acc=%0d exp 0/0/274", out_valid, busy, out_acc); end
  endtask

  task automatic test_stalls();
    do_start(4'd4);
    for (int i = 0; i < 4; i++) begin
      do_beat(1'b1, 8'd0);
      if (i < 3) begin
        tick(); tick();
        n_cmp++; if (out_count !== 5'(i + 1) || in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL stall_gap%0d got cnt=%0d rdy=%b v=%b exp %0d/1/0", i, out_count, in_ready, out_valid, i + 1); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1 || out_acc !== 12'd1024 || out_count !== 5'd4 || out_ovf !== 1'b0) begin n_err++; $display("FAIL stall_result got v=%b acc=%0d cnt=%0d ovf=%b exp 1/1024/4/0", out_valid, out_acc, out_count, out_ovf); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [11:0] exp_acc;
`ifdef ACC_SATURATE_EN
    exp_acc = 12'd4095;
`else
    exp_acc = 12'd4080;
`endif
    do_start(4'd0);
    for (int i = 0; i < 16; i++) begin
      do_beat(1'b1, 8'd255);
      if (i == 7) begin
        n_cmp++; if (out_acc !== 12'd4088 || out_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_pre got acc=%0d ovf=%b exp 4088/0", out_acc, out_ovf); end
      end
      if (i == 14) begin
        n_cmp++; if (out_valid !== 1'b0 || out_count !== 5'd15) begin n_err++; $display("FAIL ovf_len0 got v=%b cnt=%0d exp 0/15", out_valid, out_count); end
      end
    end
    n_cmp++; if (out_valid !== 1'b1 || out_acc !== exp_acc || out_ovf !== 1'b1 || out_count !== 5'd16) begin n_err++; $display("FAIL ovf_result got v=%b acc=%0d ovf=%b cnt=%0d exp 1/%0d/1/16", out_valid, out_acc, out_ovf, out_count, exp_acc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_start(4'd1);
    do_beat(1'b0, 8'd5);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); burst_len = 4'd3;
      tick();
      start = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_acc !== 12'd5 || out_count !== 5'd1 || out_ovf !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d got v=%b acc=%0d cnt=%0d ovf=%b busy=%b exp 1/5/1/0/1", i, out_valid, out_acc, out_count, out_ovf, busy); end
    end
    // start coinciding with the handshake must not launch a burst
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || out_acc !== 12'd5) begin n_err++; $display("FAIL bp_nostart got v=%b busy=%b rdy=%b acc=%0d exp 0/0/0/5", out_valid, busy, in_ready, out_acc); end
  endtask

  task automatic test_reset_mid_burst();
    do_start(4'd3);
    do_beat(1'b0, 8'd100);
    do_beat(1'b0, 8'd50);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_acc !== 12'd0 || out_count !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL midrst got acc=%0d cnt=%0d busy=%b rdy=%b exp 0/0/0/0", out_acc, out_count, busy, in_ready); end
    rst = 1'b0;
    tick();
    do_start(4'd1);
    do_beat(1'b0, 8'd7);
    n_cmp++; if (out_valid !== 1'b1 || out_acc !== 12'd7 || out_count !== 5'd1 || out_ovf !== 1'b0) begin n_err++; $display("FAIL midrst_new got v=%b acc=%0d cnt=%0d ovf=%b exp 1/7/1/0", out_valid, out_acc, out_count, out_ovf); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; burst_len = '0; in_valid = 1'b0;
    in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_stalls();
    test_overflow();
    test_backpressure();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
